// File: rtl/axis_segments_combin_nseg_pkg.sv
// Shared types for the N-segment AXI-stream combiner: FSM states and mask scan helper.
package DataInterfacePkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} seg_combin_state_e;

  localparam int unsigned MAX_SEG = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } next_bit_t;

  // Lowest set mask bit strictly above cur (cur = -1 finds the lowest set bit).
  function automatic next_bit_t next_set_bit(input logic [MAX_SEG-1:0] mask, input int cur);
    next_bit_t r;
    r = '0;
    for (int i = MAX_SEG - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_segments_combin_nseg_skid.sv
// Two-entry register slice: registered ready upstream, full throughput, stable output under stall.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 38
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty
);

  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             main_v;
  logic             skid_v;

  assign in_ready  = ~skid_v & en;
  assign out_valid = main_v & en;
  assign out_data  = main_q;
  assign empty     = ~main_v & ~skid_v;

  // Main entry drives the output; skid entry catches the beat accepted while main is stalled.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (en) begin
      if (!main_v || out_ready) begin
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else begin
          main_v <= in_valid;
          if (in_valid) main_q <= in_data;
        end
      end else if (in_valid && !skid_v) begin
        skid_q <= in_data;
        skid_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_segments_combin_nseg.sv
// N-segment AXI-stream combiner: concatenates enabled segments in index order into one packet.
module axis_segments_combin_nseg
  import DataInterfacePkg::*;
#(
  parameter int unsigned NSEG    = 3,
  parameter int unsigned DSIZE   = 32,
  parameter int unsigned KSIZE   = 4,
  parameter int          CUT_SEG = 1,
  parameter int unsigned LSIZE   = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  trigger,
  input  logic [NSEG-1:0]       seg_mask,
  input  logic [LSIZE-1:0]      cut_len,
  input  logic [NSEG*DSIZE-1:0] s_tdata,
  input  logic [NSEG*KSIZE-1:0] s_tkeep,
  input  logic [NSEG-1:0]       s_tuser,
  input  logic [NSEG-1:0]       s_tlast,
  input  logic [NSEG-1:0]       s_tvalid,
  output logic [NSEG-1:0]       s_tready,
  output logic [DSIZE-1:0]      m_tdata,
  output logic [KSIZE-1:0]      m_tkeep,
  output logic                  m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  busy
);

  localparam int unsigned CW = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned PW = DSIZE + KSIZE + 2;

  seg_combin_state_e state;
  logic [CW-1:0]     cur;
  logic [NSEG-1:0]   mask_q;
  logic [LSIZE-1:0]  cut_q;
  logic [LSIZE-1:0]  cnt;

  logic [DSIZE-1:0]  sel_data;
  logic [KSIZE-1:0]  sel_keep;
  logic              sel_user;
  logic              sel_last;
  logic              sel_valid;
  logic              in_valid;
  logic              in_ready;
  logic              fire;
  logic              is_cut;
  logic              seg_end;
  logic              last_out;
  logic              sk_empty;
  next_bit_t         first;
  next_bit_t         nxt;
  logic [PW-1:0]     out_pl;

  // Select the current segment and steer ready back to it only.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = 1'b0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    s_tready  = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (CW'(i) == cur) begin
        sel_data    = s_tdata[i*DSIZE +: DSIZE];
        sel_keep    = s_tkeep[i*KSIZE +: KSIZE];
        sel_user    = s_tuser[i];
        sel_last    = s_tlast[i];
        sel_valid   = s_tvalid[i];
        s_tready[i] = (state == RUN) & in_ready;
      end
    end
  end

  assign first    = next_set_bit(MAX_SEG'(seg_mask), -1);
  assign nxt      = next_set_bit(MAX_SEG'(mask_q), int'(cur));
  assign in_valid = (state == RUN) & sel_valid;
  assign fire     = in_valid & in_ready;
  assign is_cut   = (int'(cur) == CUT_SEG);
  // The cut segment ends on the beat count alone; its own tlast is ignored.
  assign seg_end  = is_cut ? (cnt == (cut_q - LSIZE'(1))) : sel_last;
  assign last_out = seg_end & ~nxt.found;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur    <= '0;
      mask_q <= '0;
      cut_q  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (trigger && first.found) begin
            state  <= RUN;
            busy   <= 1'b1;
            mask_q <= seg_mask;
            cut_q  <= (cut_len == '0) ? LSIZE'(1) : cut_len;
            cur    <= CW'(first.idx);
            cnt    <= '0;
          end
        end
        RUN: begin
          if (fire) begin
            if (seg_end) begin
              cnt <= '0;
              if (nxt.found) cur <= CW'(nxt.idx);
              else state <= DRAIN;
            end else if (is_cut) begin
              cnt <= cnt + LSIZE'(1);
            end
          end
        end
        DRAIN: begin
          if (sk_empty) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid_reg #(.WIDTH(PW)) u_skid (
    .clock     (clock),
    .rst_n     (rst_n),
    .en        (clk_en),
    .in_data   ({sel_data, sel_keep, sel_user, last_out}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_pl),
    .out_valid (m_tvalid),
    .out_ready (m_tready),
    .empty     (sk_empty)
  );

  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = out_pl;

endmodule

// File: tb/tb_axis_segments_combin_nseg.sv
// Directed bench for the 3-segment combiner (cut segment 1) with queue-based sources.
module tb_axis_segments_combin_nseg;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        u;
    logic        l;
  } beat_t;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        trigger;
  logic [2:0]  seg_mask;
  logic [15:0] cut_len;
  logic [95:0] s_tdata;
  logic [11:0] s_tkeep;
  logic [2:0]  s_tuser;
  logic [2:0]  s_tlast;
  logic [2:0]  s_tvalid;
  logic [2:0]  s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sq0[$];
  beat_t sq1[$];
  beat_t sq2[$];
  beat_t outq[$];
  beat_t expq[$];
  logic  got_last = 1'b0;
  logic  ready_seen = 1'b0;
  logic  rdy1_seen = 1'b0;
  logic  rand_mode = 1'b0;
  logic  chk_hold = 1'b0;
  int    pops1 = 0;
  logic  prev_v = 1'b0;
  logic  prev_r = 1'b0;
  beat_t prev_b = '0;

  axis_segments_combin_nseg #(.NSEG(3), .DSIZE(32), .KSIZE(4), .CUT_SEG(1), .LSIZE(16)) dut (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .trigger(trigger), .seg_mask(seg_mask),
    .cut_len(cut_len), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int tag, input int seg, input int beat, input logic last);
    beat_t b;
    b.d = {8'(tag), 8'(seg), 16'(beat)};
    b.k = 4'(beat + seg + 1);
    b.u = 1'(beat);
    b.l = last;
    return b;
  endfunction

  task automatic src(input int seg, input int tag, input int beat, input logic last);
    case (seg)
      0: sq0.push_back(mk(tag, seg, beat, last));
      1: sq1.push_back(mk(tag, seg, beat, last));
      default: sq2.push_back(mk(tag, seg, beat, last));
    endcase
  endtask

  task automatic expb(input int tag, input int seg, input int beat, input logic last);
    expq.push_back(mk(tag, seg, beat, last));
  endtask

  // Sources present queue heads, downstream ready follows the selected mode.
  always @(negedge clock) begin
    beat_t h;
    for (int i = 0; i < 3; i++) begin
      h = '0;
      s_tvalid[i] = 1'b0;
      case (i)
        0: if (sq0.size() > 0) begin h = sq0[0]; s_tvalid[i] = 1'b1; end
        1: if (sq1.size() > 0) begin h = sq1[0]; s_tvalid[i] = 1'b1; end
        default: if (sq2.size() > 0) begin h = sq2[0]; s_tvalid[i] = 1'b1; end
      endcase
      s_tdata[i*32 +: 32] = h.d;
      s_tkeep[i*4 +: 4]   = h.k;
      s_tuser[i]          = h.u;
      s_tlast[i]          = h.l;
    end
    m_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(posedge clock) begin
    if (chk_hold && rst_n && prev_v && !prev_r)
      chk("hold", {1'b1, m_tdata, m_tkeep, m_tuser, m_tlast}, {m_tvalid, prev_b});
    prev_v = m_tvalid;
    prev_r = m_tready;
    prev_b = {m_tdata, m_tkeep, m_tuser, m_tlast};
    if (m_tvalid && m_tready) begin
      outq.push_back({m_tdata, m_tkeep, m_tuser, m_tlast});
      if (m_tlast) got_last = 1'b1;
    end
    if (|s_tready) ready_seen = 1'b1;
    if (s_tready[1]) rdy1_seen = 1'b1;
    if (s_tvalid[0] && s_tready[0]) void'(sq0.pop_front());
    if (s_tvalid[1] && s_tready[1]) begin void'(sq1.pop_front()); pops1++; end
    if (s_tvalid[2] && s_tready[2]) void'(sq2.pop_front());
  end

  task automatic trig(input logic [2:0] mask, input logic [15:0] len);
    @(negedge clock);
    seg_mask = mask;
    cut_len  = len;
    trigger  = 1'b1;
    @(negedge clock);
    trigger  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!got_last && cyc < 400) begin @(negedge clock); cyc++; end
    chk({tag, "_tlast_seen"}, 64'(got_last), 64'(1));
    cyc = 0;
    while (busy && cyc < 50) begin @(negedge clock); cyc++; end
    chk({tag, "_busy_low"}, 64'(busy), 64'(0));
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_beats"}, 64'(outq.size()), 64'(expq.size()));
    n = (outq.size() < expq.size()) ? outq.size() : expq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), 64'(outq[i]), 64'(expq[i]));
    outq.delete();
    expq.delete();
    got_last = 1'b0;
  endtask

  initial begin
    int cyc;
    int p0;
    int o0;
    rst_n = 1'b0; clk_en = 1'b1; trigger = 1'b0; seg_mask = '0; cut_len = '0;
    repeat (3) @(negedge clock);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_payload", {m_tdata, m_tkeep, m_tuser, m_tlast}, 64'(0));
    rst_n = 1'b1;
    @(negedge clock);

    // 1: all segments, seg1 cut to 4 of 6 beats
    src(0, 1, 0, 0); src(0, 1, 1, 1);
    for (int b = 0; b < 6; b++) src(1, 1, b, 1'(b == 5));
    src(2, 1, 0, 1);
    trig(3'b111, 16'd4);
    chk("t1_busy_after_trig", 64'(busy), 64'(1));
    wait_done("t1");
    expb(1, 0, 0, 0); expb(1, 0, 1, 0);
    for (int b = 0; b < 4; b++) expb(1, 1, b, 0);
    expb(1, 2, 0, 1);
    compare("t1");
    chk("t1_seg1_left", 64'(sq1.size()), 64'(2));

    // 2: seg1 disabled
    rdy1_seen = 1'b0;
    src(0, 2, 0, 1); src(2, 2, 0, 0); src(2, 2, 1, 1);
    trig(3'b101, 16'd4);
    wait_done("t2");
    expb(2, 0, 0, 0); expb(2, 2, 0, 0); expb(2, 2, 1, 1);
    compare("t2");
    chk("t2_seg1_never_ready", 64'(rdy1_seen), 64'(0));
    chk("t2_seg1_left", 64'(sq1.size()), 64'(2));

    // 3: empty mask is ignored
    ready_seen = 1'b0;
    src(0, 3, 0, 1);
    trig(3'b000, 16'd4);
    for (int i = 0; i < 4; i++) begin @(negedge clock); chk("t3_busy", 64'(busy), 64'(0)); end
    chk("t3_no_ready", 64'(ready_seen), 64'(0));
    chk("t3_no_output", 64'(outq.size()), 64'(0));
    sq0.delete();
    @(negedge clock);

    // 4: random backpressure, cut_len 0 takes one leftover seg1 beat
    rand_mode = 1'b1; chk_hold = 1'b1;
    for (int b = 0; b < 3; b++) src(0, 4, b, 1'(b == 2));
    src(2, 4, 0, 0); src(2, 4, 1, 1);
    trig(3'b111, 16'd0);
    wait_done("t4");
    for (int b = 0; b < 3; b++) expb(4, 0, b, 0);
    expb(1, 1, 4, 0);
    expb(4, 2, 0, 0); expb(4, 2, 1, 1);
    compare("t4");
    chk("t4_seg1_left", 64'(sq1.size()), 64'(1));
    rand_mode = 1'b0; chk_hold = 1'b0;
    sq1.delete();
    @(negedge clock);

    // 5: clock enable dropped mid-seg1
    src(0, 5, 0, 1);
    for (int b = 0; b < 5; b++) src(1, 5, b, 1'(b == 4));
    pops1 = 0;
    trig(3'b011, 16'd4);
    cyc = 0;
    while (pops1 < 2 && cyc < 100) begin @(negedge clock); cyc++; end
    chk("t5_reached_seg1", 64'(pops1 >= 2), 64'(1));
    p0 = pops1; o0 = outq.size();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("t5_gated_s_tready", 64'(s_tready), 64'(0));
      chk("t5_gated_m_tvalid", 64'(m_tvalid), 64'(0));
    end
    @(negedge clock);
    chk("t5_no_input_hs", 64'(pops1), 64'(p0));
    chk("t5_no_output_hs", 64'(outq.size()), 64'(o0));
    clk_en = 1'b1;
    wait_done("t5");
    expb(5, 0, 0, 0);
    for (int b = 0; b < 4; b++) expb(5, 1, b, 1'(b == 3));
    compare("t5");
    chk("t5_seg1_left", 64'(sq1.size()), 64'(1));
    sq1.delete();
    @(negedge clock);

    // 6: reset mid-packet, then a clean packet
    for (int b = 0; b < 3; b++) src(0, 6, b, 1'(b == 2));
    for (int b = 0; b < 4; b++) src(1, 6, b, 0);
    trig(3'b011, 16'd4);
    cyc = 0;
    while (outq.size() < 2 && cyc < 100) begin @(negedge clock); cyc++; end
    chk("t6_in_flight", 64'(outq.size() >= 2), 64'(1));
    rst_n = 1'b0;
    @(posedge clock); #1;
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_s_tready", 64'(s_tready), 64'(0));
    @(negedge clock);
    rst_n = 1'b1;
    sq0.delete(); sq1.delete(); sq2.delete(); outq.delete(); got_last = 1'b0;
    src(0, 7, 0, 1); src(2, 7, 0, 1);
    trig(3'b101, 16'd4);
    wait_done("t6");
    expb(7, 0, 0, 0); expb(7, 2, 0, 1);
    compare("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
